rr_nios2_debug_host_sequencer: RTL

- Host-side initiator for the Nios II debug slave virtual-JTAG interface.
- Takes one (IR, DR) command from a system-clock request port and drives the full virtual JTAG sequence into the debug slave: update-IR, capture-DR, shift-DR, update-DR, run-test-idle.
- Returns the shifted-out DR word and the captured IR status to a response port.
- Used as the stand-in for the sld_virtual_jtag_basic hub in simulation and on-chip self-test, sitting directly on the slave's vji_* nets.

---
 rtl/rr_nios2_debug_host_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rr_nios2_debug_host_sequencer.sv
// rtl/rr_nios2_debug_host_sequencer.sv - virtual-JTAG host sequencer driving a Nios II debug slave
module rr_nios2_debug_host_sequencer #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PH_MAX = 2 * TCK_DIV - 1;
    localparam int PW     = $clog2(2 * TCK_DIV);
    localparam int BW     = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
    } state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       phase;
    logic [BW-1:0]       bit_cnt;
    logic [DR_WIDTH-1:0] sh;
    logic                ticking;
    logic                tck_rise;
    logic                tck_fall;
    logic                accept;
    logic                last_bit;

    // tck runs only while a virtual JTAG state is being walked.
    // The rise is taken on the clk edge that moves phase into the high half,
    // so slave tdo is sampled before the slave itself shifts on that tck edge.
    assign ticking  = (state != S_IDLE) && (state != S_RESP);
    assign tck_rise = ticking && (phase == PW'(TCK_DIV - 1));
    assign tck_fall = ticking && (phase == PW'(PH_MAX));
    assign accept   = cmd_valid && (state == S_IDLE);
    assign last_bit = (bit_cnt == BW'(DR_WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state decode plus strobe, handshake and tck outputs.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        vji_uir   = 1'b0;
        vji_cdr   = 1'b0;
        vji_sdr   = 1'b0;
        vji_udr   = 1'b0;
        vji_rti   = 1'b0;
        vji_tdi   = 1'b0;
        vji_tck   = ticking && (phase >= PW'(TCK_DIV));
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                vji_rti   = 1'b1;
                if (cmd_valid) state_nx = S_UIR;
            end
            S_UIR: begin
                vji_uir = 1'b1;
                if (tck_fall) state_nx = S_CDR;
            end
            S_CDR: begin
                vji_cdr = 1'b1;
                if (tck_fall) state_nx = S_SDR;
            end
            S_SDR: begin
                vji_sdr = 1'b1;
                vji_tdi = sh[0];
                if (tck_fall && last_bit) state_nx = S_UDR;
            end
            S_UDR: begin
                vji_udr = 1'b1;
                if (tck_fall) state_nx = S_RTI;
            end
            S_RTI: begin
                vji_rti = 1'b1;
                if (tck_fall) state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                vji_rti   = 1'b1;
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // tck phase counter and shift-bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            bit_cnt <= '0;
        end else begin
            if (!ticking || tck_fall) phase <= '0;
            else                      phase <= phase + 1'b1;
            if (state != S_SDR)       bit_cnt <= '0;
            else if (tck_fall)        bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Command capture, IR status sample, DR shift and response capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vji_ir_in  <= '0;
            sh         <= '0;
            rsp_ir_out <= '0;
            rsp_data   <= '0;
        end else begin
            if (accept) begin
                vji_ir_in <= cmd_ir;
                sh        <= cmd_data;
            end
            if (state == S_UIR && tck_rise) rsp_ir_out <= vji_ir_out;
            if (state == S_SDR && tck_rise) sh <= {vji_tdo, sh[DR_WIDTH-1:1]};
            if (state == S_RTI && tck_fall) rsp_data <= sh;
        end
    end

endmodule
